// File: rtl/prelab_dut.sv
// Node interface: ingress FIFO (client -> router) and registered egress path (router -> client).
// Optional macro NODE_DEST_FILTER_EN drops egress packets whose destID differs from NODE_ID.
module prelab_dut #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [3:0]  NODE_ID = 4'h0
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] data_for_fifo,
  input  logic        pkt_avail_for_fifo,
  output logic [31:0] data_fifo_router,
  output logic        data_available_tb_node_router,
  input  logic        data_taken_from_router,
  output logic        data_empty,
  output logic        fifo_full,
  input  logic [31:0] data_for_router_to_node_to_tb,
  input  logic        wr_data_to_router,
  input  logic        pkt_avail_for_node_from_router,
  output logic [31:0] data_from_router_to_node_to_tb,
  output logic        data_avail_node_tb
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            empty_q, full_q;
  logic            push, pop;

  logic [31:0]     egress_q;
  logic            egress_vld_q;
  logic            dest_ok;
  logic            egress_accept;

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    pop      = data_taken_from_router & ~empty_q;
    push     = pkt_avail_for_fifo & (~full_q | pop);
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CntFull);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b && push) begin
      mem_q[wr_ptr_q] <= data_for_fifo;
    end
  end

  assign data_fifo_router              = mem_q[rd_ptr_q];
  assign data_available_tb_node_router = ~empty_q;
  assign data_empty                    = empty_q;
  assign fifo_full                     = full_q;

`ifdef NODE_DEST_FILTER_EN
  assign dest_ok = (data_for_router_to_node_to_tb[27:24] == NODE_ID);
`else
  // Filter disabled: every destID is accepted; NODE_ID kept referenced so it never dangles.
  assign dest_ok = (data_for_router_to_node_to_tb[27:24] == NODE_ID) | 1'b1;
`endif

  assign egress_accept = wr_data_to_router & pkt_avail_for_node_from_router & dest_ok;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      egress_q     <= '0;
      egress_vld_q <= 1'b0;
    end else begin
      egress_vld_q <= egress_accept;
      if (egress_accept) begin
        egress_q <= data_for_router_to_node_to_tb;
      end
    end
  end

  assign data_from_router_to_node_to_tb = egress_q;
  assign data_avail_node_tb             = egress_vld_q;

endmodule

// File: tb/tb_prelab_dut.sv
// Directed self-checking bench for prelab_dut; expectations are hand-computed constants.
module tb_prelab_dut;

  logic        clk;
  logic        rst_b;
  logic [31:0] data_for_fifo;
  logic        pkt_avail_for_fifo;
  logic [31:0] data_fifo_router;
  logic        data_available_tb_node_router;
  logic        data_taken_from_router;
  logic        data_empty;
  logic        fifo_full;
  logic [31:0] data_for_router_to_node_to_tb;
  logic        wr_data_to_router;
  logic        pkt_avail_for_node_from_router;
  logic [31:0] data_from_router_to_node_to_tb;
  logic        data_avail_node_tb;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  prelab_dut #(
    .DEPTH   (4),
    .NODE_ID (4'h1)
  ) u_dut (
    .clk                            (clk),
    .rst_b                          (rst_b),
    .data_for_fifo                  (data_for_fifo),
    .pkt_avail_for_fifo             (pkt_avail_for_fifo),
    .data_fifo_router               (data_fifo_router),
    .data_available_tb_node_router  (data_available_tb_node_router),
    .data_taken_from_router         (data_taken_from_router),
    .data_empty                     (data_empty),
    .fifo_full                      (fifo_full),
    .data_for_router_to_node_to_tb  (data_for_router_to_node_to_tb),
    .wr_data_to_router              (wr_data_to_router),
    .pkt_avail_for_node_from_router (pkt_avail_for_node_from_router),
    .data_from_router_to_node_to_tb (data_from_router_to_node_to_tb),
    .data_avail_node_tb             (data_avail_node_tb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic empty_e, input logic full_e);
    check({tag, "_empty"}, {31'b0, data_empty}, {31'b0, empty_e});
    check({tag, "_full"}, {31'b0, fifo_full}, {31'b0, full_e});
    check({tag, "_avail"}, {31'b0, data_available_tb_node_router}, {31'b0, ~empty_e});
  endtask

  task automatic push(input logic [31:0] d);
    data_for_fifo      = d;
    pkt_avail_for_fifo = 1'b1;
    tick();
    pkt_avail_for_fifo = 1'b0;
  endtask

  task automatic egress(input logic wr, input logic vld, input logic [31:0] d);
    wr_data_to_router              = wr;
    pkt_avail_for_node_from_router = vld;
    data_for_router_to_node_to_tb  = d;
    tick();
  endtask

  logic [31:0] fill_vec  [4] = '{32'd45, 32'd32, 32'd11, 32'd65};
  logic [31:0] wrap_vec  [4] = '{32'd32, 32'd11, 32'd65, 32'd22};

  initial begin
    rst_b                          = 1'b1;
    data_for_fifo                  = '0;
    pkt_avail_for_fifo             = 1'b0;
    data_taken_from_router         = 1'b0;
    data_for_router_to_node_to_tb  = '0;
    wr_data_to_router              = 1'b0;
    pkt_avail_for_node_from_router = 1'b0;
    #2;

    // Reset held for two cycles.
    tick();
    tick();
    check_flags("rst", 1'b1, 1'b0);
    check("rst_egr_vld", {31'b0, data_avail_node_tb}, 32'd0);
    check("rst_egr_data", data_from_router_to_node_to_tb, 32'd0);
    rst_b = 1'b0;

    // Fill to full; head valid the cycle after the first push.
    push(32'd45);
    check_flags("push1", 1'b0, 1'b0);
    check("push1_head", data_fifo_router, 32'd45);
    push(32'd32);
    push(32'd11);
    check_flags("push3", 1'b0, 1'b0);
    push(32'd65);
    check_flags("push4", 1'b0, 1'b1);
    check("push4_head", data_fifo_router, 32'd45);

    // Push while full, no pop: dropped.
    push(32'd22);
    check_flags("drop", 1'b0, 1'b1);
    check("drop_head", data_fifo_router, 32'd45);

    // Pulse take four times; head order preserved.
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_head%0d", i), data_fifo_router, fill_vec[i]);
      data_taken_from_router = 1'b1;
      tick();
      data_taken_from_router = 1'b0;
      tick();
    end
    check_flags("drained", 1'b1, 1'b0);

    // Fifth take on empty is ignored; a push with take on empty is push-only.
    data_taken_from_router = 1'b1;
    tick();
    check_flags("pop_empty", 1'b1, 1'b0);
    push(32'd45);
    data_taken_from_router = 1'b0;
    check_flags("push_take_empty", 1'b0, 1'b0);
    check("push_take_empty_head", data_fifo_router, 32'd45);

    // Refill, then push 22 with take while full: slot reused, pointer wraps.
    push(32'd32);
    push(32'd11);
    push(32'd65);
    check_flags("refill", 1'b0, 1'b1);
    data_taken_from_router = 1'b1;
    push(32'd22);
    data_taken_from_router = 1'b0;
    check_flags("push_pop_full", 1'b0, 1'b1);

    // Take held high: one entry per cycle.
    data_taken_from_router = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_head%0d", i), data_fifo_router, wrap_vec[i]);
      tick();
    end
    data_taken_from_router = 1'b0;
    check_flags("wrap_drained", 1'b1, 1'b0);

    // Egress path.
    egress(1'b1, 1'b1, 32'd256);
    check("egr_vld", {31'b0, data_avail_node_tb}, 32'd1);
    check("egr_data", data_from_router_to_node_to_tb, 32'd256);
    egress(1'b0, 1'b0, 32'd999);
    check("egr_deassert_vld", {31'b0, data_avail_node_tb}, 32'd0);
    check("egr_deassert_hold", data_from_router_to_node_to_tb, 32'd256);
    egress(1'b1, 1'b0, 32'd777);
    check("egr_half_vld", {31'b0, data_avail_node_tb}, 32'd0);
    check("egr_half_hold", data_from_router_to_node_to_tb, 32'd256);

    egress(1'b1, 1'b1, 32'h0100_0005);
    check("egr_match_vld", {31'b0, data_avail_node_tb}, 32'd1);
    check("egr_match_data", data_from_router_to_node_to_tb, 32'h0100_0005);
    egress(1'b1, 1'b1, 32'h0200_0005);
`ifdef NODE_DEST_FILTER_EN
    check("egr_filt_vld", {31'b0, data_avail_node_tb}, 32'd0);
    check("egr_filt_hold", data_from_router_to_node_to_tb, 32'h0100_0005);
`else
    check("egr_other_vld", {31'b0, data_avail_node_tb}, 32'd1);
    check("egr_other_data", data_from_router_to_node_to_tb, 32'h0200_0005);
`endif

    // Reset wins over same-cycle push and egress write.
    push(32'd7);
    check_flags("pre_rst", 1'b0, 1'b0);
    rst_b                          = 1'b1;
    data_for_fifo                  = 32'd8;
    pkt_avail_for_fifo             = 1'b1;
    wr_data_to_router              = 1'b1;
    pkt_avail_for_node_from_router = 1'b1;
    data_for_router_to_node_to_tb  = 32'h0100_0009;
    tick();
    check_flags("rst_wins", 1'b1, 1'b0);
    check("rst_wins_egr_vld", {31'b0, data_avail_node_tb}, 32'd0);
    check("rst_wins_egr_data", data_from_router_to_node_to_tb, 32'd0);
    rst_b                          = 1'b0;
    pkt_avail_for_fifo             = 1'b0;
    wr_data_to_router              = 1'b0;
    pkt_avail_for_node_from_router = 1'b0;
    tick();
    check_flags("post_rst", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
